// File: rtl/softmax_pkg.sv
`default_nettype none
// ============================================================================
// Package  : softmax_pkg
// Purpose  : Shared definitions for the softmax exp-sum stage: FSM state
//            encoding, counter width, default frame geometry and a helper
//            for buffer address width.
// Revision : 1.0 - initial release
// ============================================================================
package softmax_pkg;

  localparam int CNT_W                  = 8;
  localparam int STATE_W                = 3;
  localparam int DEFAULT_DATA_SIZE      = 32;
  localparam int DEFAULT_NUMBER_OF_DATA = 10;
  localparam int DEFAULT_SUM_SIZE       = 36;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    SUM_RDY = 3'd2,
    REPLAY  = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Address bits needed to index a buffer of 'depth' entries (at least 1).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exp_sum_buffer.sv
`default_nettype none
// ============================================================================
// Module   : exp_sum_buffer
// Purpose  : Frame buffer for exp values. Synchronous single write port,
//            combinational read port. Storage is intentionally not reset.
// Ports    : clk      in  clock (rising edge)
//            wr_en    in  write enable
//            wr_addr  in  write address
//            wr_data  in  write data
//            rd_addr  in  read address
//            rd_data  out data stored at rd_addr
// Revision : 1.0 - initial release
// ============================================================================
module exp_sum_buffer #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/exp_sum_block.sv
`default_nettype none
// ============================================================================
// Module   : exp_sum_block
// Purpose  : Softmax stage after the exponent stage. Captures a frame of exp
//            values, accumulates their sum, publishes the sum, then replays
//            the buffered values to the divider over a valid/ready handshake.
// Config   : EXP_SUM_SAT_EN - when defined the accumulator clamps to all-ones
//            on carry-out; otherwise it wraps. Overflow is flagged either way.
// Ports    : clock_i            in  clock (rising edge)
//            reset_n_i          in  asynchronous active-low reset
//            sum_data_i         in  exp value from exp stage
//            sum_data_valid_i   in  sum_data_i valid (no upstream backpressure)
//            sum_done_i         in  upstream frame complete (level)
//            clear_i            in  pulse: leave DONE, start a new frame
//            out_ready_i        in  downstream accepts sum_data_o
//            sum_data_o         out replayed exp value
//            sum_data_valid_o   out replay beat valid
//            sum_total_o        out frame sum
//            sum_total_valid_o  out frame sum final
//            sum_done_o         out all entries replayed
//            sum_overflow_o     out sticky accumulator carry-out
// Revision : 1.0 - initial release
// ============================================================================
module exp_sum_block
  import softmax_pkg::*;
#(
  parameter int data_size      = DEFAULT_DATA_SIZE,
  parameter int number_of_data = DEFAULT_NUMBER_OF_DATA,
  parameter int sum_size       = DEFAULT_SUM_SIZE
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic [data_size-1:0] sum_data_i,
  input  logic                 sum_data_valid_i,
  input  logic                 sum_done_i,
  input  logic                 clear_i,
  input  logic                 out_ready_i,
  output logic [data_size-1:0] sum_data_o,
  output logic                 sum_data_valid_o,
  output logic [sum_size-1:0]  sum_total_o,
  output logic                 sum_total_valid_o,
  output logic                 sum_done_o,
  output logic                 sum_overflow_o
);

  localparam int               AW     = addr_width(number_of_data);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(number_of_data);
  localparam logic [CNT_W-1:0] N_LAST = N_CNT - ONE;

  state_t state, next_state;

  logic [CNT_W-1:0]    wr_ptr, rd_ptr, count;
  logic [sum_size-1:0] sum_q;
  logic                overflow_q;

  logic                accept;   // store + add this cycle
  logic                fire;     // replay beat transferred this cycle
  logic [sum_size:0]   add_full; // extra top bit is the carry-out
  logic [sum_size-1:0] sum_next;
  logic [data_size-1:0] rd_data;

  // --------------------------------------------------------------------------
  // Accumulator arithmetic
  // --------------------------------------------------------------------------
  assign add_full = {1'b0, sum_q} + (sum_size + 1)'(sum_data_i);

`ifdef EXP_SUM_SAT_EN
  // Once clamped, any further non-zero add carries again, so the sum stays
  // pinned at all-ones for the rest of the frame.
  assign sum_next = add_full[sum_size] ? {sum_size{1'b1}} : add_full[sum_size-1:0];
`else
  assign sum_next = add_full[sum_size-1:0];
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and datapath strobes
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (sum_data_valid_i) begin
          accept     = 1'b1;
          // A one-entry frame is already complete after the first value.
          next_state = (N_CNT == ONE) ? SUM_RDY : ACCUM;
        end else if (sum_done_i) begin
          next_state = DONE;
        end
      end
      ACCUM: begin
        if (sum_data_valid_i && (count < N_CNT)) begin
          accept = 1'b1;
        end
        // A value arriving with sum_done_i is accepted on the same edge.
        if (accept && (count == N_LAST)) begin
          next_state = SUM_RDY;
        end else if (sum_done_i) begin
          next_state = SUM_RDY;
        end
      end
      SUM_RDY: begin
        next_state = REPLAY;
      end
      REPLAY: begin
        if (out_ready_i) begin
          fire = 1'b1;
          if (rd_ptr == (count - ONE)) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
        if (clear_i) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointers, count and accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
    end else if ((state == DONE) && clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      // In IDLE the accumulator is already zero, so the add yields the value.
      if (accept) begin
        sum_q      <= sum_next;
        overflow_q <= overflow_q | add_full[sum_size];
        wr_ptr     <= wr_ptr + ONE;
        count      <= count + ONE;
      end
      if (fire) begin
        rd_ptr <= rd_ptr + ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame buffer
  // --------------------------------------------------------------------------
  exp_sum_buffer #(
    .WIDTH  (data_size),
    .DEPTH  (number_of_data),
    .ADDR_W (AW)
  ) u_buffer (
    .clk     (clock_i),
    .wr_en   (accept),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (sum_data_i),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  // --------------------------------------------------------------------------
  // Outputs (all derived from registered state, zero in IDLE)
  // --------------------------------------------------------------------------
  assign sum_data_valid_o  = (state == REPLAY);
  // Buffer is not reset, so gate the read data to keep outputs zero outside replay.
  assign sum_data_o        = sum_data_valid_o ? rd_data : '0;
  assign sum_total_o       = sum_q;
  assign sum_total_valid_o = (state == SUM_RDY) || (state == REPLAY) || (state == DONE);
  assign sum_done_o        = (state == DONE);
  assign sum_overflow_o    = overflow_q;

endmodule
`default_nettype wire
